// File: rtl/afifo_ctrl_pkg.sv
// Shared definitions for the async FIFO read-side burst controller.
package afifo_ctrl_pkg;

    localparam int BURST_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_e;

endpackage

// File: rtl/afifo_rd_burst_ctrl_if.sv
// Consumer-facing port: burst request/ack negotiation plus the valid/ready beat stream.
interface afifo_rd_burst_ctrl_if #(
    parameter int RD_DATA_WIDTH = 64,
    parameter int LEN_W         = 9
);
    logic                     burst_req;
    logic [LEN_W-1:0]         burst_len;
    logic                     burst_ack;
    logic [RD_DATA_WIDTH-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;

    // Controller side
    modport master (
        output burst_req, burst_len, m_data, m_valid, m_last,
        input  burst_ack, m_ready
    );

    // Consumer side
    modport slave (
        input  burst_req, burst_len, m_data, m_valid, m_last,
        output burst_ack, m_ready
    );
endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order skid buffer that absorbs the FIFO's one-cycle read latency.
// Entry 0 is always the head; a pop shifts entry 1 down.
module rd_skid_buf #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid
);
    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        occ_q, occ_d;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop && (occ_q != 2'd0);
    assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

    // Next entry contents and occupancy for every push/pop combination
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = push_data;
                else               ent1_d = push_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = push_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // Entry and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data entries are reset too, because the head entry is the visible m_data and must read 0 out of reset.
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge value regardless of statement order.
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ        = occ_q;
    assign head_data  = ent0_q;
    assign head_valid = (occ_q != 2'd0);
endmodule

// File: rtl/afifo_rd_burst_ctrl.sv
// Read-side burst sequencer: waits for enough FIFO occupancy (or a flush),
// negotiates a burst with the consumer, then streams exactly burst_len beats.
module afifo_rd_burst_ctrl
    import afifo_ctrl_pkg::*;
#(
    parameter int RD_DEPTH_WIDTH = 8,
    parameter int RD_DATA_WIDTH  = 64,
    parameter int BURST_LEN      = 16,
    parameter int LEN_W          = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     fifo_rd_en,
    input  logic [RD_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                     fifo_rd_empty,
    input  logic [RD_DEPTH_WIDTH:0]  fifo_rd_water_level,
    input  logic                     flush,
    afifo_rd_burst_ctrl_if.master    bus,
    output logic                     busy,
    output logic [BURST_CNT_W-1:0]   burst_cnt
);
    localparam logic [RD_DEPTH_WIDTH:0] LVL_THRESH = (RD_DEPTH_WIDTH + 1)'(BURST_LEN);
    localparam logic [LEN_W-1:0]        LEN_FULL   = LEN_W'(BURST_LEN);

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         issued_q, issued_d;
    logic [LEN_W-1:0]         beats_q, beats_d;
    logic                     flush_pend_q, flush_pend_d;
    logic                     inflight_q, inflight_d;
    logic [BURST_CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]               occ;
    logic [2:0]               proj_occ;
    logic                     head_valid;
    logic [RD_DATA_WIDTH-1:0] head_data;
    logic                     pop;
    logic                     last_beat;
    logic                     rd_en;

    rd_skid_buf #(.DATA_W(RD_DATA_WIDTH)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_q),
        .push_data  (fifo_rd_data),
        .pop        (pop),
        .occ        (occ),
        .head_data  (head_data),
        .head_valid (head_valid)
    );

    assign pop       = head_valid && bus.m_ready;
    assign last_beat = head_valid && ((beats_q + LEN_W'(1)) == len_q);
    // Skid slots that will be committed after this edge; issuing keeps it at most 2.
    assign proj_occ  = 3'(occ) + 3'(inflight_q) - 3'(pop);

    // Read issue: only while transferring, within the burst, never on empty, never past 2 outstanding
    always_comb begin
        rd_en = (state_q == ST_XFER) && (issued_q < len_q) && !fifo_rd_empty && (proj_occ < 3'd2);
    end

    // Next-state, burst length capture, issue/beat counters and flush tracking
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        issued_d     = issued_q;
        beats_d      = beats_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        inflight_d   = rd_en;
        if (rd_en) issued_d = issued_q + LEN_W'(1);
        if (pop)   beats_d  = beats_q + LEN_W'(1);
        case (state_q)
            ST_IDLE: begin
                issued_d = '0;
                beats_d  = '0;
                if (fifo_rd_water_level >= LVL_THRESH) begin
                    state_d = ST_REQ;
                    len_d   = LEN_FULL;
                end else if (flush_pend_q && (fifo_rd_water_level != '0)) begin
                    state_d = ST_REQ;
                    len_d   = LEN_W'(fifo_rd_water_level);
                end
                if (fifo_rd_empty) flush_pend_d = 1'b0;
            end
            ST_REQ: begin
                if (bus.burst_ack) state_d = ST_XFER;
            end
            ST_XFER: begin
                if (pop && last_beat) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + BURST_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new flush request takes priority over clearing a pending one.
        if (flush) flush_pend_d = 1'b1;
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            issued_q     <= '0;
            beats_q      <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            beats_q      <= beats_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            inflight_q   <= inflight_d;
        end
    end

    assign fifo_rd_en    = rd_en;
    assign bus.burst_req = (state_q == ST_REQ);
    assign bus.burst_len = len_q;
    assign bus.m_data    = head_data;
    assign bus.m_valid   = head_valid;
    assign bus.m_last    = last_beat;
    assign busy          = (state_q != ST_IDLE);
    assign burst_cnt     = cnt_q;
endmodule
